// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - serial pattern transmitter, MSB first, with start/busy/done handshake
// Optional inter-repetition gap compiled in with SEQ_GEN_GAP_EN.
module seq_gen #(
    parameter int PAT_W   = 8,
    parameter int LEN_W   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [7:0]       rep_cnt,
    output logic             busy,
    output logic             dout,
    output logic             dout_vld,
    output logic             frame_end,
    output logic             done
);

    if (((1 << LEN_W) <= PAT_W) || (GAP_CYC < 0)) begin : g_bad_param
        $error("seq_gen: LEN_W too narrow for PAT_W or negative GAP_CYC");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
`ifdef SEQ_GEN_GAP_EN
        ST_GAP  = 2'd3,
`endif
        ST_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [7:0]       reps_q, reps_d;
    logic [7:0]       rep_q, rep_d;
    logic             busy_q, busy_d;
    logic             dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             fe_q, fe_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_clamped;

`ifdef SEQ_GEN_GAP_EN
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    logic [GW-1:0] gap_q, gap_d;
`endif

    function automatic logic pat_bit(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
        logic [PAT_W-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    assign len_clamped = ((pat_len == '0) || (pat_len > LEN_W'(PAT_W))) ? LEN_W'(PAT_W) : pat_len;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        reps_d  = reps_q;
        rep_d   = rep_q;
        busy_d  = 1'b0;
        dout_d  = 1'b0;
        vld_d   = 1'b0;
        fe_d    = 1'b0;
        done_d  = 1'b0;
`ifdef SEQ_GEN_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    len_d   = len_clamped;
                    reps_d  = rep_cnt;
                    rep_d   = 8'd0;
                    idx_d   = len_clamped - LEN_W'(1);
                    state_d = ST_SEND;
                    busy_d  = 1'b1;
                    vld_d   = 1'b1;
                    dout_d  = pat_bit(pattern, len_clamped - LEN_W'(1));
                    fe_d    = (len_clamped == LEN_W'(1));
                end
            end
            ST_SEND: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (idx_q != '0) begin
                    idx_d  = idx_q - LEN_W'(1);
                    busy_d = 1'b1;
                    vld_d  = 1'b1;
                    dout_d = pat_bit(pat_q, idx_q - LEN_W'(1));
                    fe_d   = (idx_q == LEN_W'(1));
                end else begin
                    rep_d  = rep_q + 8'd1;
                    busy_d = 1'b1;
                    if ((reps_q != 8'd0) && (rep_q + 8'd1 == reps_q)) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
`ifdef SEQ_GEN_GAP_EN
                    end else if (GAP_CYC > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GW'(GAP_CYC - 1);
`endif
                    end else begin
                        // back-to-back: next frame's MSB follows bit 0 with no bubble
                        idx_d  = len_q - LEN_W'(1);
                        vld_d  = 1'b1;
                        dout_d = pat_bit(pat_q, len_q - LEN_W'(1));
                        fe_d   = (len_q == LEN_W'(1));
                    end
                end
            end
`ifdef SEQ_GEN_GAP_EN
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (gap_q != '0) begin
                    gap_d  = gap_q - GW'(1);
                    busy_d = 1'b1;
                end else begin
                    state_d = ST_SEND;
                    idx_d   = len_q - LEN_W'(1);
                    busy_d  = 1'b1;
                    vld_d   = 1'b1;
                    dout_d  = pat_bit(pat_q, len_q - LEN_W'(1));
                    fe_d    = (len_q == LEN_W'(1));
                end
            end
`endif
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            reps_q  <= '0;
            rep_q   <= '0;
            busy_q  <= 1'b0;
            dout_q  <= 1'b0;
            vld_q   <= 1'b0;
            fe_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            reps_q  <= reps_d;
            rep_q   <= rep_d;
            busy_q  <= busy_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            fe_q    <= fe_d;
            done_q  <= done_d;
`ifdef SEQ_GEN_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign dout      = dout_q;
    assign dout_vld  = vld_q;
    assign frame_end = fe_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - directed self-checking bench for seq_gen
module tb_seq_gen;

`ifdef SEQ_GEN_GAP_EN
    localparam int GAPN = 2;
`else
    localparam int GAPN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [3:0] pat_len = 4'd0;
    logic [7:0] rep_cnt = 8'd0;
    logic       busy, dout, dout_vld, frame_end, done;

    int n_cmp = 0;
    int n_bad = 0;

    seq_gen #(.PAT_W(8), .LEN_W(4), .GAP_CYC(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .pattern  (pattern),
        .pat_len  (pat_len),
        .rep_cnt  (rep_cnt),
        .busy     (busy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .frame_end(frame_end),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 (first output cycle after the start edge).
    task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [7:0] r);
        pattern = p;
        pat_len = l;
        rep_cnt = r;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++;
        if ({busy, dout, dout_vld, frame_end, done} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_hold: outputs=%b expected=00000", {busy, dout, dout_vld, frame_end, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({busy, dout, dout_vld, frame_end, done} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_release: outputs=%b expected=00000", {busy, dout, dout_vld, frame_end, done});
        end
    endtask

    task automatic test_single();
        logic [4:0] e5;
        e5 = 5'b10110;
        launch(8'b0001_0110, 4'd5, 8'd1);
        for (int c = 1; c <= 7; c++) begin
            logic ev, ed;
            ev = (c <= 5);
            ed = ev ? e5[5-c] : 1'b0;
            n_cmp++;
            if ({busy, dout_vld, dout, frame_end, done} !== {(c <= 6), ev, ed, (c == 5), (c == 6)}) begin
                n_bad++;
                $display("FAIL single c%0d: busy/vld/dout/fe/done=%b expected=%b", c,
                         {busy, dout_vld, dout, frame_end, done}, {(c <= 6), ev, ed, (c == 5), (c == 6)});
            end
            step();
        end
    endtask

    task automatic test_repeat();
        logic [14:0] e15;
        e15 = 15'b101101011010110;
        launch(8'b0001_0110, 4'd5, 8'd3);
        for (int c = 1; c <= 17; c++) begin
            logic ev, ed, ef;
            ev = (c <= 15);
            ed = ev ? e15[15-c] : 1'b0;
            ef = (c == 5) || (c == 10) || (c == 15);
            n_cmp++;
            if ({busy, dout_vld, dout, frame_end, done} !== {(c <= 16), ev, ed, ef, (c == 16)}) begin
                n_bad++;
                $display("FAIL repeat c%0d: busy/vld/dout/fe/done=%b expected=%b", c,
                         {busy, dout_vld, dout, frame_end, done}, {(c <= 16), ev, ed, ef, (c == 16)});
            end
            step();
        end
    endtask

    task automatic test_gap();
        logic [4:0] e5;
        e5 = 5'b10110;
        launch(8'b0001_0110, 4'd5, 8'd2);
        for (int c = 1; c <= 14; c++) begin
            logic ev, ed;
            int   p;
            ev = (c <= 5) || (c >= 8 && c <= 12);
            p  = (c <= 5) ? c : c - 7;
            ed = ev ? e5[5-p] : 1'b0;
            n_cmp++;
            if ({busy, dout_vld, dout, frame_end, done} !== {(c <= 13), ev, ed, (c == 5 || c == 12), (c == 13)}) begin
                n_bad++;
                $display("FAIL gap c%0d: busy/vld/dout/fe/done=%b expected=%b", c,
                         {busy, dout_vld, dout, frame_end, done}, {(c <= 13), ev, ed, (c == 5 || c == 12), (c == 13)});
            end
            step();
        end
    endtask

    task automatic test_abort();
        logic [4:0] e5;
        int         seen_done;
        e5 = 5'b10110;
        seen_done = 0;
        launch(8'b0001_0110, 4'd5, 8'd0);
        for (int c = 1; c <= 12; c++) begin
            int   p;
            logic ev, ed;
            p  = (c - 1) % (5 + GAPN);
            ev = (p < 5);
            ed = ev ? e5[4-p] : 1'b0;
            n_cmp++;
            if ({busy, dout_vld, dout, frame_end, done} !== {1'b1, ev, ed, (p == 4), 1'b0}) begin
                n_bad++;
                $display("FAIL abort_run c%0d: busy/vld/dout/fe/done=%b expected=%b", c,
                         {busy, dout_vld, dout, frame_end, done}, {1'b1, ev, ed, (p == 4), 1'b0});
            end
            if (c == 12) stop = 1'b1;
            step();
        end
        stop = 1'b0;
        n_cmp++;
        if ({busy, dout_vld, dout, frame_end, done} !== 5'b0) begin
            n_bad++;
            $display("FAIL abort_c13: busy/vld/dout/fe/done=%b expected=00000", {busy, dout_vld, dout, frame_end, done});
        end
        for (int c = 14; c <= 18; c++) begin
            if (done || busy || dout_vld) seen_done++;
            step();
        end
        n_cmp++;
        if (seen_done !== 0) begin
            n_bad++;
            $display("FAIL abort_quiet: active cycles=%0d expected=0", seen_done);
        end
    endtask

    task automatic test_clamp();
        logic [7:0] e8;
        e8 = 8'hA5;
        launch(8'hA5, 4'd0, 8'd1);
        for (int c = 1; c <= 10; c++) begin
            logic ev, ed;
            ev = (c <= 8);
            ed = ev ? e8[8-c] : 1'b0;
            n_cmp++;
            if ({busy, dout_vld, dout, frame_end, done} !== {(c <= 9), ev, ed, (c == 8), (c == 9)}) begin
                n_bad++;
                $display("FAIL clamp c%0d: busy/vld/dout/fe/done=%b expected=%b", c,
                         {busy, dout_vld, dout, frame_end, done}, {(c <= 9), ev, ed, (c == 8), (c == 9)});
            end
            if (c == 2) pattern = 8'hFF;
            start = (c == 4);
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_start_stop();
        pattern = 8'b0000_0110;
        pat_len = 4'd3;
        rep_cnt = 8'd1;
        start   = 1'b1;
        stop    = 1'b1;
        step();
        start   = 1'b0;
        stop    = 1'b0;
        n_cmp++;
        if ({busy, dout_vld, dout, frame_end} !== 4'b1110) begin
            n_bad++;
            $display("FAIL start_stop: busy/vld/dout/fe=%b expected=1110", {busy, dout_vld, dout, frame_end});
        end
        step();
        step();
        n_cmp++;
        if ({dout_vld, dout, frame_end} !== 3'b101) begin
            n_bad++;
            $display("FAIL start_stop_last: vld/dout/fe=%b expected=101", {dout_vld, dout, frame_end});
        end
        step();
        step();
    endtask

    task automatic test_reset_mid();
        logic [4:0] e5;
        e5 = 5'b10110;
        launch(8'b0001_0110, 4'd5, 8'd1);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, dout, dout_vld, frame_end, done} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_mid: outputs=%b expected=00000", {busy, dout, dout_vld, frame_end, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        launch(8'b0001_0110, 4'd5, 8'd1);
        for (int c = 1; c <= 6; c++) begin
            logic ev, ed;
            ev = (c <= 5);
            ed = ev ? e5[5-c] : 1'b0;
            n_cmp++;
            if ({busy, dout_vld, dout, done} !== {1'b1, ev, ed, (c == 6)}) begin
                n_bad++;
                $display("FAIL reset_restart c%0d: busy/vld/dout/done=%b expected=%b", c,
                         {busy, dout_vld, dout, done}, {1'b1, ev, ed, (c == 6)});
            end
            step();
        end
        step();
    endtask

    task automatic test_loopback();
        logic [4:0] sr;
        int         hits;
        sr   = 5'b0;
        hits = 0;
        launch(8'b0001_0110, 4'd5, 8'd1);
        for (int c = 1; c <= 8; c++) begin
            if (dout_vld) begin
                sr = {sr[3:0], dout};
                if (sr == 5'b10110) hits++;
            end
            step();
        end
        n_cmp++;
        if (hits !== 1) begin
            n_bad++;
            $display("FAIL loopback: detections=%0d expected=1", hits);
        end
    endtask

    initial begin
        test_reset();
        test_single();
`ifdef SEQ_GEN_GAP_EN
        test_gap();
`else
        test_repeat();
`endif
        test_abort();
        test_clamp();
        test_start_stop();
        test_reset_mid();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Serial pattern transmitter. Emits a programmable bit pattern, MSB first, on a single-bit output, one bit per clk.
- Counterpart of the serial sequence detector. Default pattern 10110 drives detector stimulus and on-chip loopback self-test.
- Start/busy/done handshake. Pattern is repeated a programmable number of times, or continuously until stopped.

Parameters:
- PAT_W, 8, maximum pattern width in bits.
- LEN_W, 4, width of pat_len. Must satisfy 2^LEN_W > PAT_W.
- GAP_CYC, 2, idle cycles between repetitions. Used only when SEQ_GEN_GAP_EN is defined.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  launch request. Sampled only in IDLE.
- stop  in  1  abort request. Honoured in SEND and GAP.
- pattern  in  PAT_W  bits to send. Active bits are [pat_len-1:0].
- pat_len  in  LEN_W  number of bits per repetition.
- rep_cnt  in  8  number of repetitions. 0 = continuous.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- dout  out  1  serial data. 0 whenever dout_vld is 0.
- dout_vld  out  1  dout carries a pattern bit.
- frame_end  out  1  asserted with the last bit of each repetition.
- done  out  1  one-cycle pulse after the final repetition completes normally.

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk.
  - All outputs reset to 0. State resets to IDLE. Internal counters reset to 0.
- All outputs are registered.
- States: IDLE, SEND, GAP, FIN. Binary encoding is acceptable.
- IDLE:
  - start=1 at edge N: latch pattern, pat_len and rep_cnt into shadow registers; go to SEND.
  - First bit appears on dout with dout_vld=1 in cycle N+1. Latency is 1 cycle.
  - Inputs changing after the start edge have no effect until the next start.
- Length clamp: pat_len=0 or pat_len>PAT_W is treated as PAT_W.
- SEND:
  - Outputs shadow bit index len-1 down to 0, one per cycle, using a bit counter.
  - On bit 0, frame_end=1 for that cycle.
  - After bit 0:
    - If the repetition counter reaches the latched rep_cnt (rep_cnt≠0): go to FIN.
    - Otherwise: go to GAP if the feature is enabled, else go straight back to SEND at bit len-1 (back-to-back, no bubble).
- GAP: holds dout_vld=0 and dout=0 for GAP_CYC cycles, then goes to SEND.
- FIN: done=1 and busy=1 for exactly one cycle, then IDLE (busy=0 the next cycle).
- Repetition counter: 8 bits.
  - rep_cnt=0 means continuous mode. The counter does not saturate the decision; the block runs until stop.
- stop in SEND or GAP:
  - Abort takes effect on the next edge: dout_vld=0 and dout=0, no frame_end, no done.
  - Go to IDLE. busy drops the cycle after stop is sampled.
- stop in IDLE or FIN is ignored.
- Simultaneous start and stop in IDLE: start wins; stop is ignored.
- start while busy is ignored. It is not queued.
- Reset asserted mid-frame: outputs clear immediately (asynchronous). No done pulse.
- Single-bit pattern (pat_len=1): every SEND cycle has frame_end=1.

Optional Feature:
- Macro: SEQ_GEN_GAP_EN.
- Defined:
  - GAP state and a GAP_CYC down-counter are compiled in.
  - GAP_CYC idle cycles are inserted between repetitions, never after the final one.
- Undefined:
  - No GAP state or gap counter exists.
  - Repetitions are back-to-back with dout_vld held continuously 1 across frame boundaries.
  - GAP_CYC is unused.

Test Plan:
- Default case, macro off: pattern=8'b0001_0110, pat_len=5, rep_cnt=1, start pulse at cycle 0.
  - dout=1,0,1,1,0 with dout_vld=1 in cycles 1-5.
  - frame_end in cycle 5, done in cycle 6, busy in cycles 1-6.
- Repetition, macro off: same pattern, rep_cnt=3.
  - 15 contiguous valid bits, 101101011010110.
  - frame_end in cycles 5, 10 and 15; done in cycle 16.
- Gap, macro on, GAP_CYC=2, rep_cnt=2.
  - Bits in cycles 1-5 and 8-12; dout_vld=0 in cycles 6-7.
  - done in cycle 13.
- Continuous and abort: rep_cnt=0, pat_len=5; assert stop at cycle 12 (mid-frame).
  - Last valid bit in cycle 12; dout_vld=0 from cycle 13.
  - No done; busy=0 from cycle 13.
- Length clamp and input isolation: pat_len=0, pattern=8'hA5, rep_cnt=1.
  - 8 bits 10100101 are sent.
  - Changing pattern to 8'hFF in cycle 2 does not alter the output.
  - start pulsed in cycle 4 is ignored.
- Reset mid-frame: rst_n low in cycle 3.
  - All outputs 0 immediately.
  - After release, a new start sends a full frame from bit len-1.
- Closed-loop check: connect dout, gated by dout_vld, to the serial sequence detector.
  - Default pattern with rep_cnt=1 produces one detection (two-cycle high result).
